// File: rtl/fifo_rd_packer_if.sv
// Bundle between the FIFO read port, the packer and its downstream consumer.
// master = packer side, slave = FIFO/consumer environment side.
`timescale 1ns/1ps
interface fifo_rd_packer_if #(
    parameter int DW    = 8,
    parameter int RATIO = 4
);
    logic                  fifo_ren;
    logic [DW-1:0]         fifo_rdata;
    logic                  fifo_rempty;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DW*RATIO-1:0]   m_data;
    logic [RATIO-1:0]      m_keep;

    modport master (
        output fifo_ren, m_valid, m_data, m_keep,
        input  fifo_rdata, fifo_rempty, flush, m_ready
    );

    modport slave (
        input  fifo_ren, m_valid, m_data, m_keep,
        output fifo_rdata, fifo_rempty, flush, m_ready
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs RATIO consecutive FIFO read words into one wide beat, with flush of partial words.
// Optional read counter port stat_words enabled by defining FIFO_RD_PACKER_STAT_EN.
`timescale 1ns/1ps
module fifo_rd_packer #(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_packer_if.master bus
`ifdef FIFO_RD_PACKER_STAT_EN
    ,
    output logic [31:0]      stat_words
`endif
);
    localparam int CW = $clog2(RATIO + 1);
    localparam int PW = DW * RATIO;

    typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   lane_cnt_q, lane_cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic [PW-1:0]   pack_q, pack_d;
    logic            m_valid_q, m_valid_d;
    logic [PW-1:0]   m_data_q, m_data_d;
    logic [RATIO-1:0] m_keep_q, m_keep_d;

    logic            slot_free, full, xfer, room, ren, load;
    logic [CW-1:0]   wr_lane;

    assign slot_free = !m_valid_q || bus.m_ready;
    assign full      = (lane_cnt_q == CW'(RATIO));
    assign xfer      = full && slot_free;
    assign room      = ({1'b0, lane_cnt_q} + {{CW{1'b0}}, rd_pend_q}) < (CW+1)'(RATIO);
    assign ren       = !rst && !bus.fifo_rempty && (state_q == RUN) && (room || xfer);
    assign load      = xfer || ((state_q == EMIT) && slot_free);
    // A word landing in the same cycle the pack register empties goes to lane 0.
    assign wr_lane   = load ? '0 : lane_cnt_q;
    assign rd_pend_d = ren;

    always_comb begin
        pack_d     = pack_q;
        lane_cnt_d = lane_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        if (load) begin
            m_data_d   = pack_q;
            m_valid_d  = 1'b1;
            for (int i = 0; i < RATIO; i++) begin
                m_keep_d[i] = (CW'(i) < lane_cnt_q);
            end
            pack_d     = '0;
            lane_cnt_d = '0;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
        if (rd_pend_q) begin
            for (int i = 0; i < RATIO; i++) begin
                if (CW'(i) == wr_lane) begin
                    pack_d[i*DW +: DW] = bus.fifo_rdata;
                end
            end
            lane_cnt_d = wr_lane + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.flush) state_d = DRAIN;
            DRAIN:   if (!rd_pend_q) state_d = (lane_cnt_d != '0) ? EMIT : RUN;
            EMIT:    if (slot_free) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            lane_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            pack_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            rd_pend_q  <= rd_pend_d;
            pack_q     <= pack_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
        end
    end

    assign bus.fifo_ren = ren;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_keep   = m_keep_q;

`ifdef FIFO_RD_PACKER_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (ren) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_words = stat_q;
`endif
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DW, default 8, input word width taken from the async FIFO read port.
REQ-002 Parameter RATIO, default 4, number of input words packed per output word; legal range 2..16.
REQ-003 Port clk  input  1  single clock, same domain as the FIFO read side.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port fifo_ren  output  1  read enable to the FIFO read port.
REQ-006 Port fifo_rdata  input  DW  FIFO read data, registered, valid one cycle after an accepted read.
REQ-007 Port fifo_rempty  input  1  FIFO empty flag.
REQ-008 Port flush  input  1  single-cycle pulse; emit any partially packed word.
REQ-009 Port m_valid  output  1  output word valid.
REQ-010 Port m_ready  input  1  downstream accept.
REQ-011 Port m_data  output  DW*RATIO  packed word; lane 0 is bits [DW-1:0] and holds the earliest input word.
REQ-012 Port m_keep  output  RATIO  per-lane filled flags.

Function
REQ-013 fifo_ren SHALL be combinational: !rempty && state==RUN && (lane_cnt+rd_pend<RATIO || xfer).
- xfer means lane_cnt==RATIO and the output slot is free (m_valid==0 or m_ready==1).
REQ-014 rd_pend SHALL be set in the cycle after fifo_ren&&!fifo_rempty and cleared otherwise.
- While rd_pend==1, fifo_rdata SHALL be written into lane lane_cnt, or lane 0 if xfer occurs in that same cycle.
- lane_cnt SHALL be updated accordingly, range 0..RATIO.
REQ-015 On xfer: pack register SHALL load m_data, m_keep SHALL be all ones, m_valid SHALL become 1 next cycle, lane_cnt SHALL go to 0 (or 1 if a word lands in the same cycle).
REQ-016 m_data and m_keep SHALL remain stable while m_valid && !m_ready; m_valid SHALL drop after a handshake unless a new xfer/emit occurs in that cycle.
REQ-017 Sustained throughput SHALL be at least RATIO input words per RATIO+1 cycles when the FIFO is never empty and m_ready is held high.
REQ-018 Three states:
- RUN: flush moves to DRAIN.
- DRAIN: no reads; waits until rd_pend==0, then moves to EMIT if lane_cnt>0, else to RUN.
- EMIT: waits for a free output slot, loads the partial word, then moves to RUN.
REQ-019 A partial word SHALL have m_keep[i]=1 for i<lane_cnt and 0 otherwise; unfilled lanes SHALL be zero in m_data.
REQ-020 flush SHALL be ignored outside RUN; flush with lane_cnt==0 and rd_pend==0 SHALL produce no output.
REQ-021 flush in the same cycle as xfer: xfer SHALL complete first, then DRAIN proceeds with the remaining lanes.
REQ-022 fifo_rempty rising with rd_pend==1: the in-flight word SHALL still be captured.

Reset
REQ-023 On rst, the block SHALL force:
- m_valid=0, m_data=0, m_keep=0
- lane_cnt=0, rd_pend=0, state=RUN, pack register zero
- fifo_ren=0 in the reset cycle
REQ-024 Reset mid-operation SHALL discard the in-flight and packed words; no recovery of words already popped from the FIFO.

Configuration
REQ-025 Macro FIFO_RD_PACKER_STAT_EN defined:
- output port stat_words, 32 bits, counts every accepted FIFO read.
- Wraps modulo 2^32; reset to 0.
REQ-026 FIFO_RD_PACKER_STAT_EN undefined: port stat_words and its counter SHALL be absent; all other behaviour is identical.

Verification (DW=8, RATIO=4)
REQ-027 FIFO holds 0x11,0x22,0x33,0x44 and m_ready=1 -> one beat m_data=0x44332211, m_keep=4'b1111.
REQ-028 12 words streamed, m_ready=1 -> 3 beats in order; reads never stall beyond one bubble per beat.
REQ-029 m_ready=0 with 8 words available -> fifo_ren stops after 8 reads (4 held in m_data, 4 packed); m_data stays stable; releasing m_ready yields both beats in order.
REQ-030 3 words (0xA1,0xB2,0xC3) then flush -> m_data=0x00C3B2A1, m_keep=4'b0111; flush with nothing buffered -> no beat.
REQ-031 rst asserted while rd_pend=1 and lane_cnt=2 -> next cycle m_valid=0, lane_cnt=0; the following 4 words form a clean beat.
REQ-032 With FIFO_RD_PACKER_STAT_EN defined, after REQ-028 -> stat_words=12.
